// File: rtl/mc_ctrl_hs_if.sv
// Signal bundle between the multicycle controller and its datapath/memory.
// The controller sits on the master modport; the datapath side uses slave.
interface mc_ctrl_hs_if #(
  parameter int CNT_W = 32
);
  logic             zero;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             mem_ready;
  logic             reg_write;
  logic             mem_write;
  logic             mem_req;
  logic             pc_write;
  logic             ir_write;
  logic             ext_op;
  logic             ext5_src;
  logic             iord;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       pc_source;
  logic [1:0]       gpr_sel;
  logic [1:0]       wd_sel;
  logic [3:0]       alu_op;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;
  logic             bus_err;

  modport master (
    input  zero, opcode, funct, mem_ready,
    output reg_write, mem_write, mem_req, pc_write, ir_write, ext_op, ext5_src, iord,
           alu_src_a, alu_src_b, pc_source, gpr_sel, wd_sel, alu_op, state, instret, bus_err
  );

  modport slave (
    output zero, opcode, funct, mem_ready,
    input  reg_write, mem_write, mem_req, pc_write, ir_write, ext_op, ext5_src, iord,
           alu_src_a, alu_src_b, pc_source, gpr_sel, wd_sel, alu_op, state, instret, bus_err
  );
endinterface

// File: rtl/mc_ctrl_hs.sv
// Multicycle MIPS-subset controller with memory handshake timeout and retired-instruction count.
// Define MC_CTRL_ILLEGAL_TRAP_EN to send unlisted instructions through the TRAP state.
module mc_ctrl_hs #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic         clk,
  input logic         rst,
  mc_ctrl_hs_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXE    = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    ERR    = 3'd5,
    TRAP   = 3'd6
  } state_t;

  localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [5:0] OP_R = 6'd0,  OP_J = 6'd2,  OP_JAL = 6'd3,  OP_BEQ = 6'd4;
  localparam logic [5:0] OP_BNE = 6'd5, OP_ADDI = 6'd8, OP_SLTI = 6'd10, OP_ANDI = 6'd12;
  localparam logic [5:0] OP_ORI = 6'd13, OP_LUI = 6'd15, OP_LW = 6'd35, OP_SW = 6'd43;

  state_t           state, state_next;
  logic [CNT_W-1:0] instret;
  logic             bus_err;
  logic [WCW-1:0]   wait_cnt;
  logic             timeout;

  logic [3:0] ins_alu_op;
  logic is_j, is_jal, is_jr, is_jalr, is_beq, is_bne, is_lw, is_sw;
  logic is_imm, is_zext, is_shift, is_shiftv, legal;

  // Instruction classification; only meaningful once the IR holds the fetched word.
  always_comb begin
    ins_alu_op = 4'b0001;
    is_j = 1'b0; is_jal = 1'b0; is_jr = 1'b0; is_jalr = 1'b0;
    is_beq = 1'b0; is_bne = 1'b0; is_lw = 1'b0; is_sw = 1'b0;
    is_imm = 1'b0; is_zext = 1'b0; is_shift = 1'b0; is_shiftv = 1'b0;
    legal = 1'b1;
    case (bus.opcode)
      OP_R: begin
        case (bus.funct)
          6'd32: ins_alu_op = 4'b0001;
          6'd33: ins_alu_op = 4'b1001;
          6'd34: ins_alu_op = 4'b0010;
          6'd35: ins_alu_op = 4'b1010;
          6'd36: ins_alu_op = 4'b0011;
          6'd37: ins_alu_op = 4'b0100;
          6'd39: ins_alu_op = 4'b0110;
          6'd42: ins_alu_op = 4'b0111;
          6'd43: ins_alu_op = 4'b1000;
          6'd0:  begin ins_alu_op = 4'b1011; is_shift = 1'b1; end
          6'd2:  begin ins_alu_op = 4'b1101; is_shift = 1'b1; end
          6'd4:  begin ins_alu_op = 4'b1011; is_shift = 1'b1; is_shiftv = 1'b1; end
          6'd6:  begin ins_alu_op = 4'b1101; is_shift = 1'b1; is_shiftv = 1'b1; end
          6'd8:  is_jr = 1'b1;
          6'd9:  is_jalr = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      OP_J:    is_j = 1'b1;
      OP_JAL:  is_jal = 1'b1;
      OP_BEQ:  begin ins_alu_op = 4'b0010; is_beq = 1'b1; end
      OP_BNE:  begin ins_alu_op = 4'b0010; is_bne = 1'b1; end
      OP_ADDI: begin ins_alu_op = 4'b0001; is_imm = 1'b1; end
      OP_SLTI: begin ins_alu_op = 4'b0111; is_imm = 1'b1; end
      OP_ANDI: begin ins_alu_op = 4'b0011; is_imm = 1'b1; is_zext = 1'b1; end
      OP_ORI:  begin ins_alu_op = 4'b0100; is_imm = 1'b1; is_zext = 1'b1; end
      OP_LUI:  begin ins_alu_op = 4'b1100; is_imm = 1'b1; end
      OP_LW:   is_lw = 1'b1;
      OP_SW:   is_sw = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // A completing access beats the timeout in the same cycle.
  assign timeout = (wait_cnt == WAIT_LAST) && !bus.mem_ready;

  always_comb begin
    state_next    = state;
    bus.reg_write = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_req   = 1'b0;
    bus.pc_write  = 1'b0;
    bus.ir_write  = 1'b0;
    bus.ext_op    = 1'b1;
    bus.ext5_src  = 1'b0;
    bus.iord      = 1'b0;
    bus.alu_src_a = 2'd1;
    bus.alu_src_b = 2'd0;
    bus.pc_source = 2'd0;
    bus.gpr_sel   = 2'd0;
    bus.wd_sel    = 2'd0;
    bus.alu_op    = 4'b0001;
    case (state)
      FETCH: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_a = 2'd0;
        bus.alu_src_b = 2'd1;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_next   = DECODE;
        end else if (timeout) begin
          state_next = ERR;
        end
      end
      DECODE: begin
        if (is_j || is_jal) begin
          bus.pc_write  = 1'b1;
          bus.pc_source = 2'd2;
          if (is_jal) begin
            bus.reg_write = 1'b1;
            bus.wd_sel    = 2'd2;
            bus.gpr_sel   = 2'd2;
          end
          state_next = FETCH;
        end else if (is_jr || is_jalr) begin
          bus.pc_write  = 1'b1;
          bus.pc_source = 2'd3;
          if (is_jalr) begin
            bus.reg_write = 1'b1;
            bus.wd_sel    = 2'd2;
            bus.gpr_sel   = 2'd2;
          end
          state_next = FETCH;
        end else begin
          bus.alu_src_a = 2'd0;
          bus.alu_src_b = 2'd3;
          state_next    = (legal || !TRAP_EN) ? EXE : TRAP;
        end
      end
      EXE: begin
        bus.alu_op = ins_alu_op;
        if (is_beq || is_bne) begin
          bus.pc_source = 2'd1;
          bus.pc_write  = is_beq ? bus.zero : !bus.zero;
          state_next    = FETCH;
        end else if (is_lw || is_sw) begin
          bus.alu_src_b = 2'd2;
          state_next    = MEM;
        end else begin
          if (is_imm)    bus.alu_src_b = 2'd2;
          if (is_zext)   bus.ext_op    = 1'b0;
          if (is_shift)  bus.alu_src_a = 2'd2;
          if (is_shiftv) bus.ext5_src  = 1'b1;
          state_next = WB;
        end
      end
      MEM: begin
        bus.mem_req   = 1'b1;
        bus.iord      = 1'b1;
        bus.mem_write = is_sw;
        if (bus.mem_ready) state_next = is_lw ? WB : FETCH;
        else if (timeout)  state_next = ERR;
      end
      WB: begin
        bus.reg_write = 1'b1;
        if (is_lw) bus.wd_sel = 2'd1;
        if (is_lw || is_imm) bus.gpr_sel = 2'd1;
        state_next = FETCH;
      end
      ERR: state_next = ERR;
      TRAP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'd2;
        state_next    = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  // Retirement is counted on the way back to FETCH; TRAP returns are not retirements.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      instret  <= '0;
      bus_err  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next == FETCH && (state == DECODE || state == EXE || state == MEM || state == WB))
        instret <= instret + CNT_W'(1);
      if (state_next == ERR)
        bus_err <= 1'b1;
      if (state_next != state && (state_next == FETCH || state_next == MEM))
        wait_cnt <= '0;
      else if (bus.mem_req && !bus.mem_ready && wait_cnt != WAIT_LAST)
        wait_cnt <= wait_cnt + WCW'(1);
    end
  end

  assign bus.state   = state;
  assign bus.instret = instret;
  assign bus.bus_err = bus_err;

endmodule
